// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 decode definitions. Holds the base opcode
//               constants, the immediate-format enum, and a helper that maps
//               an opcode to its immediate format.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } imm_fmt_e;

  // Any opcode outside the supported base set is reported as FMT_ILL.
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      OP_OP:                    fmt = FMT_R;
      default:                  fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32 immediate generator. Produces the
//               sign-extended immediate for I/S/B/U/J formats, zero for R-type,
//               and zero plus an illegal flag for unsupported opcodes.
// Ports       : instr   (in,  32) instruction word
//               imm     (out, 32) sign-extended immediate
//               illegal (out, 1)  opcode is not a supported base opcode
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic        illegal
);

  imm_fmt_e w_fmt;

  assign w_fmt = opcode_fmt(instr[6:0]);

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (w_fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      FMT_R: imm = '0;
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule : imm_gen
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Single-entry RV32 decode pipeline stage with valid/ready
//               handshakes on both sides, register-file operand capture,
//               load-use bubble insertion and a bubble counter.
// Config      : DECODE_WB_BYPASS_EN - when defined, a same-cycle writeback
//               (wb_we/wb_rd/wb_data) is forwarded into the source operands.
//               Undefined (default): rf_rd1/rf_rd2 are used unmodified and the
//               wb_* ports are ignored.
// Ports       : clk, rst               clock, synchronous active-high reset
//               in_valid/in_ready      fetch-side handshake
//               in_instr, in_pc        incoming instruction and PC
//               flush                  discard stage contents
//               rf_a1/a2, rf_rd1/rd2   register-file read port
//               wb_we/wb_rd/wb_data    writeback (bypass source)
//               out_valid/out_ready    execute-side handshake
//               out_*                  decoded bundle
//               stall_cnt              number of load-use bubbles inserted
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic            out_illegal,
  output logic [31:0]     stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            illegal;
  } bundle_t;

  // --------------------------------------------------------------------------
  // Field extraction and immediate generation
  // --------------------------------------------------------------------------
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [6:0]      w_opcode;
  logic [31:0]     w_imm;
  logic            w_illegal;
  imm_fmt_e        w_fmt;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  bundle_t         w_dec;

  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_rd     = in_instr[11:7];
  assign w_opcode = in_instr[6:0];
  assign w_fmt    = opcode_fmt(w_opcode);

  assign rf_a1 = w_rs1;
  assign rf_a2 = w_rs2;

  imm_gen u_imm_gen (
    .instr   (in_instr),
    .imm     (w_imm),
    .illegal (w_illegal)
  );

`ifdef DECODE_WB_BYPASS_EN
  // The register file writes synchronously, so a writeback landing this
  // cycle is not yet visible on rf_rd*; forward it directly.
  assign w_src1 = (wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs1)) ? wb_data : rf_rd1;
  assign w_src2 = (wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs2)) ? wb_data : rf_rd2;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_we, wb_rd, wb_data};
  assign w_src1      = rf_rd1;
  assign w_src2      = rf_rd2;
`endif

  always_comb begin
    w_dec           = '0;
    w_dec.pc        = in_pc;
    w_dec.rs1       = w_rs1;
    w_dec.rs2       = w_rs2;
    w_dec.rd        = w_rd;
    w_dec.opcode    = w_opcode;
    w_dec.funct3    = in_instr[14:12];
    w_dec.funct7b5  = in_instr[30];
    // x0 always reads as zero regardless of what the register file returns.
    w_dec.rs1_val   = (w_rs1 == 5'd0) ? '0 : w_src1;
    w_dec.rs2_val   = (w_rs2 == 5'd0) ? '0 : w_src2;
    w_dec.imm       = w_imm;
    w_dec.illegal   = w_illegal;
    w_dec.mem_read  = (w_opcode == OP_LOAD);
    w_dec.mem_write = (w_opcode == OP_STORE);
    w_dec.reg_write = ((w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                       (w_fmt == FMT_U) || (w_fmt == FMT_J)) && (w_rd != 5'd0);
  end

  // --------------------------------------------------------------------------
  // Handshake, hazard and state update
  // --------------------------------------------------------------------------
  logic        valid_q, valid_d;
  bundle_t     bundle_q, bundle_d;
  logic [31:0] stall_q, stall_d;
  logic        w_lu_hazard;
  logic        w_accept;

  // out_rd is checked rather than reg_write: a load keeps its rd even when the
  // write enable is gated, and rd==0 is excluded explicitly.
  assign w_lu_hazard = valid_q && bundle_q.mem_read && (bundle_q.rd != 5'd0) &&
                       in_valid && ((w_rs1 == bundle_q.rd) || (w_rs2 == bundle_q.rd));

  assign in_ready = !rst && !flush && !w_lu_hazard && (!valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    stall_d  = stall_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d  = 1'b1;
      bundle_d = w_dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
      // The load drains while the dependent instruction is held: one bubble.
      if (w_lu_hazard) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      stall_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = bundle_q.pc;
  assign out_rs1_val   = bundle_q.rs1_val;
  assign out_rs2_val   = bundle_q.rs2_val;
  assign out_imm       = bundle_q.imm;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_rd        = bundle_q.rd;
  assign out_opcode    = bundle_q.opcode;
  assign out_funct3    = bundle_q.funct3;
  assign out_funct7b5  = bundle_q.funct7b5;
  assign out_mem_read  = bundle_q.mem_read;
  assign out_mem_write = bundle_q.mem_write;
  assign out_reg_write = bundle_q.reg_write;
  assign out_illegal   = bundle_q.illegal;
  assign stall_cnt     = stall_q;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage. Expected
//               values are hand-computed from the instruction encodings.
// Config      : DECODE_WB_BYPASS_EN selects the expected bypass result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_mem_read, out_mem_write, out_reg_write, out_illegal;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .rf_a1        (rf_a1),
    .rf_a2        (rf_a2),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_val  (out_rs1_val),
    .out_rs2_val  (out_rs2_val),
    .out_imm      (out_imm),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_mem_read (out_mem_read),
    .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write),
    .out_illegal  (out_illegal),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    rf_rd1 = '0; rf_rd2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // ---------------- addi x5,x0,7 ----------------
    in_valid = 1'b1; in_instr = 32'h00700293; in_pc = 32'h100;
    rf_rd1 = 32'h55; rf_rd2 = 32'h22;
    #1;
    check("addi_rf_a1", rf_a1, 0);
    check("addi_rf_a2", rf_a2, 7);
    step();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_imm", out_imm, 7);
    check("addi_rd", out_rd, 5);
    check("addi_rs1", out_rs1, 0);
    check("addi_rs1_val", out_rs1_val, 0);
    check("addi_rs2_val", out_rs2_val, 32'h22);
    check("addi_reg_write", out_reg_write, 1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_opcode", out_opcode, 7'h13);
    step();
    check("addi_drain", out_valid, 0);

    // ---------------- lw x6,0(x5) then add x7,x6,x5 ----------------
    in_valid = 1'b1; in_instr = 32'h0002A303; in_pc = 32'h104;
    rf_rd1 = 32'h1000; rf_rd2 = 32'h0;
    step();
    in_instr = 32'h005303B3; in_pc = 32'h108; rf_rd1 = 32'h2000; rf_rd2 = 32'h1000;
    #1;
    check("lw_valid", out_valid, 1);
    check("lw_mem_read", out_mem_read, 1);
    check("lw_rd", out_rd, 6);
    check("lw_rs1_val", out_rs1_val, 32'h1000);
    check("hazard_in_ready", in_ready, 0);
    step();
    check("bubble_valid", out_valid, 0);
    check("bubble_stall_cnt", stall_cnt, 1);
    check("bubble_in_ready", in_ready, 1);
    step();
    check("add_valid", out_valid, 1);
    check("add_rd", out_rd, 7);
    check("add_rs1_val", out_rs1_val, 32'h2000);
    check("add_rs2_val", out_rs2_val, 32'h1000);
    check("add_imm", out_imm, 0);
    check("add_reg_write", out_reg_write, 1);
    check("add_stall_cnt", stall_cnt, 1);

    // ---------------- back-pressure hold, sw x7,4(x5) waiting ----------------
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0072A223; in_pc = 32'h10C;
    rf_rd1 = 32'h55; rf_rd2 = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      rf_rd1 = rf_rd1 + 32'h1;
      check("hold_valid", out_valid, 1);
      check("hold_rd", out_rd, 7);
      check("hold_pc", out_pc, 32'h108);
      check("hold_rs1_val", out_rs1_val, 32'h2000);
      check("hold_in_ready", in_ready, 0);
    end
    rf_rd1 = 32'h55; out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    step();
    check("sw_pc", out_pc, 32'h10C);
    check("sw_mem_write", out_mem_write, 1);
    check("sw_mem_read", out_mem_read, 0);
    check("sw_imm", out_imm, 4);
    check("sw_reg_write", out_reg_write, 0);
    check("sw_rs2", out_rs2, 7);
    check("sw_rs1_val", out_rs1_val, 32'h55);
    check("sw_rs2_val", out_rs2_val, 32'h77);

    // ---------------- writeback bypass: addi x8,x3,-1 ----------------
    in_instr = 32'hFFF18413; in_pc = 32'h110; rf_rd1 = 32'h0; rf_rd2 = 32'h31;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
    check("byp_rf_a1", rf_a1, 3);
    step();
    wb_we = 1'b0; in_valid = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    exp_byp = 32'hDEADBEEF;
`else
    exp_byp = 32'h0;
`endif
    check("byp_rs1_val", out_rs1_val, exp_byp);
    check("byp_rs2_val", out_rs2_val, 32'h31);
    check("byp_imm", out_imm, 32'hFFFFFFFF);
    check("byp_rd", out_rd, 8);

    // ---------------- flush with a held bundle ----------------
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100493; in_pc = 32'h114;
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_no_capture_rd", out_rd, 8);
    check("flush_stall_cnt", stall_cnt, 1);
    out_ready = 1'b1;
    step();
    check("post_flush_valid", out_valid, 1);
    check("post_flush_rd", out_rd, 9);
    check("post_flush_imm", out_imm, 1);

    // ---------------- immediate formats and illegal opcode ----------------
    vecs[0] = '{instr: 32'h123450B7, imm: 32'h12345000, rw: 1'b1, ill: 1'b0}; // lui x1,0x12345
    vecs[1] = '{instr: 32'hFE208CE3, imm: 32'hFFFFFFF8, rw: 1'b0, ill: 1'b0}; // beq x1,x2,-8
    vecs[2] = '{instr: 32'h001000EF, imm: 32'h00000800, rw: 1'b1, ill: 1'b0}; // jal x1,2048
    vecs[3] = '{instr: 32'hFFF0057F, imm: 32'h00000000, rw: 1'b0, ill: 1'b1}; // opcode 0x7F
    rf_rd1 = 32'h0; rf_rd2 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      in_instr = vecs[i].instr; in_pc = 32'h200 + 32'(i * 4);
      step();
      check("vec_valid", out_valid, 1);
      check("vec_imm", out_imm, vecs[i].imm);
      check("vec_reg_write", out_reg_write, {31'b0, vecs[i].rw});
      check("vec_illegal", out_illegal, {31'b0, vecs[i].ill});
      check("vec_mem_read", out_mem_read, 0);
    end

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0; in_instr = 32'h00100493; rst = 1'b1;
    #1;
    check("rstmid_in_ready", in_ready, 0);
    step();
    check("rstmid_valid", out_valid, 0);
    check("rstmid_pc", out_pc, 0);
    check("rstmid_rd", out_rd, 0);
    check("rstmid_opcode", out_opcode, 0);
    check("rstmid_illegal", out_illegal, 0);
    check("rstmid_stall_cnt", stall_cnt, 0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_decode_stage
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; 32 is the only supported value.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts it
- in_instr  in  32  instruction
- in_pc  in  32  instruction PC
- flush  in  1  discard all contents
- rf_a1, rf_a2  out  5 each  register-file read addresses (combinational from in_instr)
- rf_rd1, rf_rd2  in  32 each  register-file combinational read data
- wb_we  in  1  writeback write enable
- wb_rd  in  5  writeback address
- wb_data  in  32  writeback data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  32 each
- out_rs1, out_rs2, out_rd  out  5 each
- out_opcode  out  7
- out_funct3  out  3
- out_funct7b5  out  1
- out_mem_read, out_mem_write, out_reg_write, out_illegal  out  1 each
- stall_cnt  out  32  load-use bubble count

Function
REQ-003 SHALL drive rf_a1=in_instr[19:15] and rf_a2=in_instr[24:20] combinationally.
REQ-004 SHALL set in_ready = !rst & !flush & !lu_hazard & (!out_valid | out_ready).
REQ-005 SHALL capture a bundle on in_valid & in_ready, appearing on outputs next cycle with out_valid=1 (1-cycle latency).
REQ-006 SHALL hold all out_* stable while out_valid & !out_ready.
REQ-007 SHALL clear out_valid when out_ready and no new capture occurs.
REQ-008 SHALL generate out_imm by opcode: I (0000011, 0010011, 1100111), S (0100011), B (1100011), U (0110111, 0010111), J (1101111), all sign-extended; R-type (0110011) gives 0.
REQ-009 SHALL set out_illegal=1, out_reg_write=0, out_mem_read=0, out_mem_write=0, and out_imm=0 for any other opcode.
REQ-010 SHALL set out_mem_read only for opcode 0000011, and out_mem_write only for 0100011.
REQ-011 SHALL set out_reg_write for R, I, U and J types only when rd != 0.
REQ-012 SHALL force out_rs1_val/out_rs2_val to 0 when the corresponding source index is 0.
REQ-013 SHALL define lu_hazard = out_valid & out_mem_read & out_rd!=0 & in_valid & (rs1==out_rd | rs2==out_rd).
- out_rd remains valid for a load even though out_reg_write is gated by rd!=0.
REQ-014 SHALL, when lu_hazard & out_ready, insert exactly one bubble: out_valid=0 next cycle, incoming instruction accepted the following cycle.
REQ-015 SHALL increment stall_cnt (wrapping at 2^32) once per inserted bubble.
REQ-016 SHALL, on flush, clear out_valid next cycle, accept nothing that cycle, and leave stall_cnt unchanged.
- Flush has priority over capture and hazard.

Reset
REQ-017 SHALL, on rst, clear out_valid, all out_* data fields and stall_cnt to 0 at the next clock edge.
REQ-018 SHALL hold in_ready=0 while rst is high; reset mid-transfer discards the held bundle.

Configuration
REQ-019 SHALL, with DECODE_WB_BYPASS_EN defined, select wb_data instead of rf_rd1/rf_rd2 when wb_we & wb_rd!=0 & wb_rd equals the source index.
- This covers a same-cycle writeback that the synchronous-write register file does not yet show.
REQ-020 SHALL, without DECODE_WB_BYPASS_EN, use rf_rd1/rf_rd2 unmodified; wb_* ports remain present and unused.

Structure
REQ-021 SHALL take opcode constants and an immediate-format enum from shared package riscv_pkg.
REQ-022 SHALL place immediate generation in one combinational sub-module imm_gen (in instr, out imm, illegal).

Verification
REQ-023 Bench SHALL cover:
- addi x5,x0,7 (0x00700293) -> out_imm=7, out_rd=5, out_rs1=0, out_rs1_val=0, out_reg_write=1, out_valid one cycle later.
- lw x6,0(x5) (0x0002A303) followed by add x7,x6,x5 (0x005303B3), out_ready=1 -> one bubble, stall_cnt=1, add emitted two cycles after lw.
- out_ready=0 for 3 cycles with bundle held -> out_* stable, in_ready=0; release -> next instruction accepted same cycle.
- Read of x3 while wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, rf_rd1=0 -> out_rs1_val=0xDEADBEEF with DECODE_WB_BYPASS_EN, 0 without.
- flush asserted with valid bundle held -> out_valid=0 next cycle, no capture.
- Opcode 0x7F -> out_illegal=1, out_imm=0, out_reg_write=0.
- rst mid-stream -> all outputs 0 next cycle.
